// File: rtl/fetchinstrgen_mul_pipe.sv
// fetchinstrgen_mul_pipe: pipelined integer multiplier with a valid/ready handshake.
//   The full product and its overflow flag are formed in stage 0. Later stages only carry them.
//   Ports:
//     ap_clk, ap_rst_n      clock, asynchronous active-low reset
//     in_valid/in_ready     operand handshake (din0, din1)
//     out_valid/out_ready   result handshake (dout, dout_ovf)
//     busy                  any stage holds valid data
//   FETCHINSTRGEN_MUL_PIPE_SAT_EN: when defined, an overflowing result saturates instead of wrapping.
module fetchinstrgen_mul_pipe #(
  parameter int DIN0_WIDTH = 16,
  parameter int DIN1_WIDTH = 16,
  parameter int DOUT_WIDTH = 20,
  parameter int NUM_STAGE  = 3,
  parameter int SIGNED     = 0
) (
  input  logic                  ap_clk,
  input  logic                  ap_rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DIN0_WIDTH-1:0] din0,
  input  logic [DIN1_WIDTH-1:0] din1,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DOUT_WIDTH-1:0] dout,
  output logic                  dout_ovf,
  output logic                  busy
);
  localparam int PW = DIN0_WIDTH + DIN1_WIDTH;
  localparam int N  = NUM_STAGE;
  logic [PW-1:0]         a_ext, b_ext, p;
  logic signed [PW-1:0]  p_sh;
  logic                  ovf;
  logic [DOUT_WIDTH-1:0] res;
  logic [N-1:0]          v_q, v_d, o_q, o_d, adv;
  logic [DOUT_WIDTH-1:0] d_q [N];
  logic [DOUT_WIDTH-1:0] d_d [N];
  logic                  in_xfer;
`ifdef FETCHINSTRGEN_MUL_PIPE_SAT_EN
  logic [DOUT_WIDTH-1:0] max_v;
`endif
  // Both operands are extended to the full product width, so the low PW bits of the product are exact for either signedness.
  always_comb begin
    a_ext = {{DIN1_WIDTH{(SIGNED != 0) && din0[DIN0_WIDTH-1]}}, din0};
    b_ext = {{DIN0_WIDTH{(SIGNED != 0) && din1[DIN1_WIDTH-1]}}, din1};
    p     = a_ext * b_ext;
    p_sh  = $signed(p) >>> (DOUT_WIDTH - 1);
    ovf   = (SIGNED != 0) ? !(p_sh == '0 || p_sh == '1) : (p >> DOUT_WIDTH) != '0;
`ifdef FETCHINSTRGEN_MUL_PIPE_SAT_EN
    max_v = {DOUT_WIDTH{1'b1}} >> (SIGNED != 0);
    res   = !ovf ? p[DOUT_WIDTH-1:0] : ((SIGNED != 0) && p[PW-1]) ? ~max_v : max_v;
`else
    res   = p[DOUT_WIDTH-1:0];
`endif
  end
  // Stage k may advance unless it and every stage after it are full while the output is stalled.
  always_comb begin
    for (int k = 0; k < N; k++)
      adv[k] = out_ready || !(&(v_q | ~({N{1'b1}} << k)));
  end
  assign in_ready = ap_rst_n && adv[0];
  assign in_xfer  = in_valid && in_ready;
  always_comb begin
    v_d[0] = adv[0] ? in_xfer : v_q[0];
    o_d[0] = (adv[0] && in_xfer) ? ovf : o_q[0];
    d_d[0] = (adv[0] && in_xfer) ? res : d_q[0];
    for (int k = 1; k < N; k++) begin
      v_d[k] = adv[k] ? v_q[k-1] : v_q[k];
      o_d[k] = (adv[k] && v_q[k-1]) ? o_q[k-1] : o_q[k];
      d_d[k] = (adv[k] && v_q[k-1]) ? d_q[k-1] : d_q[k];
    end
  end
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      v_q <= '0;
      o_q <= '0;
      for (int k = 0; k < N; k++) d_q[k] <= '0;
    end else begin
      v_q <= v_d;
      o_q <= o_d;
      d_q <= d_d;
    end
  end
  assign out_valid = v_q[N-1];
  assign dout      = d_q[N-1];
  assign dout_ovf  = o_q[N-1];
  assign busy      = |v_q;
endmodule

// File: tb/tb_fetchinstrgen_mul_pipe.sv
// tb_fetchinstrgen_mul_pipe: scoreboard bench for three configurations.
//   u0 is unsigned with 3 stages, u1 is signed with 3 stages, and u2 is unsigned with 1 stage.
module tb_fetchinstrgen_mul_pipe;
  logic clk = 0, rst_n = 0;
  always #5 clk = ~clk;
  logic iv [3], ir [3], ov [3], orr [3], ovf [3], bz [3], ordef [3];
  logic [15:0] a [3], b [3];
  logic [19:0] d [3];
  logic pat_en = 0;
  int pcnt = 0;
  int tests = 0, fails = 0;
  int occ;
  logic [20:0] q0 [$], q1 [$], q2 [$];
  logic stall_p [3];
  logic [20:0] last_p [3];

  fetchinstrgen_mul_pipe #(.NUM_STAGE(3), .SIGNED(0)) u0 (.ap_clk(clk), .ap_rst_n(rst_n), .in_valid(iv[0]), .in_ready(ir[0]),
    .din0(a[0]), .din1(b[0]), .out_valid(ov[0]), .out_ready(orr[0]), .dout(d[0]), .dout_ovf(ovf[0]), .busy(bz[0]));
  fetchinstrgen_mul_pipe #(.NUM_STAGE(3), .SIGNED(1)) u1 (.ap_clk(clk), .ap_rst_n(rst_n), .in_valid(iv[1]), .in_ready(ir[1]),
    .din0(a[1]), .din1(b[1]), .out_valid(ov[1]), .out_ready(orr[1]), .dout(d[1]), .dout_ovf(ovf[1]), .busy(bz[1]));
  fetchinstrgen_mul_pipe #(.NUM_STAGE(1), .SIGNED(0)) u2 (.ap_clk(clk), .ap_rst_n(rst_n), .in_valid(iv[2]), .in_ready(ir[2]),
    .din0(a[2]), .din1(b[2]), .out_valid(ov[2]), .out_ready(orr[2]), .dout(d[2]), .dout_ovf(ovf[2]), .busy(bz[2]));

  // Drives out_ready: either the repeating 1,0,0,1 pattern or a per-DUT constant level.
  always @(negedge clk) begin
    pcnt++;
    for (int k = 0; k < 3; k++) orr[k] = pat_en ? (pcnt % 4 == 0 || pcnt % 4 == 3) : ordef[k];
  end

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [20:0] model(int k, logic [15:0] x, logic [15:0] y);
    longint p;
    logic [19:0] r;
    logic o;
    p = (k == 1) ? longint'($signed(x)) * longint'($signed(y)) : longint'(x) * longint'(y);
    o = (k == 1) ? (p > 524287 || p < -524288) : (p > 1048575);
    r = p[19:0];
`ifdef FETCHINSTRGEN_MUL_PIPE_SAT_EN
    if (o) r = (k != 1) ? 20'hFFFFF : (p < 0) ? 20'h80000 : 20'h7FFFF;
`endif
    return {o, r};
  endfunction

  function automatic int depth(int k);
    return (k == 2) ? 1 : 3;
  endfunction

  function automatic int qsize(int k);
    return (k == 0) ? q0.size() : (k == 1) ? q1.size() : q2.size();
  endfunction

  function automatic logic [20:0] qpop(int k);
    if (k == 0) return q0.pop_front();
    if (k == 1) return q1.pop_front();
    return q2.pop_front();
  endfunction

  task automatic qpush(int k, logic [20:0] v);
    if (k == 0) q0.push_back(v);
    else if (k == 1) q1.push_back(v);
    else q2.push_back(v);
  endtask

  // Sample midway between clock edges. The queue length equals the number of results in flight.
  always @(negedge clk) begin
    #3;
    for (int k = 0; k < 3; k++) begin
      if (rst_n) begin
        occ = qsize(k);
        chk("in_ready", ir[k], !(occ == depth(k) && !orr[k]));
        chk("busy", bz[k], occ != 0);
        if (stall_p[k] && ov[k]) chk("hold", {ovf[k], d[k]}, last_p[k]);
        if (ov[k] && orr[k]) begin
          if (occ == 0) chk("spurious_out", ov[k], 0);
          else chk("result", {ovf[k], d[k]}, qpop(k));
        end
      end
      stall_p[k] = rst_n && ov[k] && !orr[k];
      last_p[k] = {ovf[k], d[k]};
    end
  end

  task automatic send(int k, logic [15:0] x, logic [15:0] y);
    int n = 0;
    @(negedge clk);
    iv[k] = 1; a[k] = x; b[k] = y;
    #1;
    while (!ir[k] && n < 50) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk("accept", ir[k], 1);
    if (ir[k]) begin
      @(posedge clk);
      qpush(k, model(k, x, y));
    end
  endtask

  task automatic idle(int k);
    @(negedge clk);
    iv[k] = 0;
  endtask

  task automatic drain(int k);
    for (int n = 0; n < 100 && qsize(k) != 0; n++) @(negedge clk);
    chk("drain", qsize(k), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int k = 0; k < 3; k++) begin
      iv[k] = 0; a[k] = 0; b[k] = 0; ordef[k] = 1;
    end
    rst_n = 0;
    repeat (2) @(negedge clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      chk("rst_in_ready", ir[k], 0);
      chk("rst_out_valid", ov[k], 0);
      chk("rst_busy", bz[k], 0);
      chk("rst_dout", {ovf[k], d[k]}, 0);
    end
    @(negedge clk);
    rst_n = 1;
    send(0, 3, 5);
    @(negedge clk); iv[0] = 0; #1 chk("lat_c1", ov[0], 0);
    @(negedge clk); #1 chk("lat_c2", ov[0], 0);
    @(negedge clk); #1 chk("lat_c3", ov[0], 1);
    chk("t1_dout", {ovf[0], d[0]}, 21'h0000F);
    drain(0);
    send(2, 3, 5);
    @(negedge clk); iv[2] = 0; #1 chk("lat1_c1", ov[2], 1);
    chk("t1s1_dout", {ovf[2], d[2]}, 21'h0000F);
    drain(2);
    send(0, 16'hFFFF, 16'hFFFF);
    send(0, 16'h0400, 16'h0400);
    send(0, 16'h03FF, 16'h0400);
    idle(0); drain(0);
    send(1, 16'hFFFD, 16'd5);
    send(1, 16'h8000, 16'h8000);
    send(1, 16'hFFFF, 16'hFFFF);
    send(1, 16'h0200, 16'hFC00);
    idle(1); drain(1);
    pat_en = 1;
    for (int i = 1; i <= 8; i++) send(0, 16'(i), 16'(i));
    idle(0); drain(0);
    for (int i = 1; i <= 8; i++) send(2, 16'(i), 16'(i));
    idle(2); drain(2);
    pat_en = 0;
    ordef[0] = 0;
    for (int i = 0; i < 3; i++) send(0, 16'd10, 16'd10);
    @(negedge clk);
    a[0] = 16'd11; b[0] = 16'd11;
    #1 chk("full_in_ready", ir[0], 0);
    chk("full_busy", bz[0], 1);
    ordef[0] = 1;
    send(0, 16'd11, 16'd11);
    @(negedge clk); iv[0] = 0; #1 chk("swap_busy", bz[0], 1);
    drain(0);
    ordef[0] = 0;
    send(0, 16'd2, 16'd3);
    send(0, 16'd4, 16'd5);
    @(negedge clk);
    iv[0] = 0; rst_n = 0;
    q0.delete(); q1.delete(); q2.delete();
    #1 chk("mid_rst_out_valid", ov[0], 0);
    chk("mid_rst_busy", bz[0], 0);
    chk("mid_rst_dout", {ovf[0], d[0]}, 0);
    chk("mid_rst_in_ready", ir[0], 0);
    @(negedge clk);
    rst_n = 1; ordef[0] = 1;
    send(0, 16'd7, 16'd7);
    idle(0); drain(0);
    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
